// File: rtl/status_display_gen.sv
// Status indicator driver: turns attempt results into a timed tri-colour LED
// indication (green on success, blinking red on failure, solid red during
// lockout after repeated failures) and shows a count on a small LED bank.
// Timing is expressed in 1 ms ticks derived from the clock by a prescaler.

module status_display_gen #(
  parameter int N_LEDS    = 4,
  parameter int CW        = 4,
  parameter int TICK_DIV  = 5000,
  parameter int HOLD_MS   = 2000,
  parameter int BLINK_MS  = 250,
  parameter int MAX_FAILS = 3,
  parameter int LOCK_MS   = 10000,
  parameter int THERMO    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        status,
  input  logic [CW-1:0]     count,
  output logic [1:0]        tri_colour,
  output logic [N_LEDS-1:0] leds
);

  // Counter widths: each counter only ever holds 0 .. limit-1 before it is
  // cleared or the state exits, so $clog2(limit) bits never wrap.
  localparam int MS_MAX  = (HOLD_MS > LOCK_MS) ? HOLD_MS : LOCK_MS;
  localparam int PRESC_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int MS_W    = (MS_MAX    > 1) ? $clog2(MS_MAX)    : 1;
  localparam int BLINK_W = (BLINK_MS  > 1) ? $clog2(BLINK_MS)  : 1;
  localparam int FAIL_W  = (MAX_FAILS > 1) ? $clog2(MAX_FAILS) : 1;

  localparam logic [1:0] STATUS_FAIL    = 2'b01;
  localparam logic [1:0] STATUS_SUCCESS = 2'b10;

  localparam logic [1:0] COLOUR_OFF   = 2'b00;
  localparam logic [1:0] COLOUR_RED   = 2'b01;
  localparam logic [1:0] COLOUR_GREEN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FAIL,
    ST_SUCCESS,
    ST_LOCKOUT
  } state_t;

  state_t              state;
  logic [1:0]          status_q;
  logic [1:0]          status_prev;
  logic                q_valid;
  logic                prev_valid;
  logic [FAIL_W-1:0]   fail_cnt;
  logic [PRESC_W-1:0]  presc;
  logic [MS_W-1:0]     ms;
  logic [BLINK_W-1:0]  blink;
  logic [N_LEDS-1:0]   count_disp;

  logic evt_change;
  logic fail_evt;
  logic succ_evt;
  logic take_evt;
  logic fail_last;
  logic tick;
  logic hold_done;
  logic lock_done;
  logic blink_flip;

  // Status history. The valid bits keep a status that is already nonzero when
  // reset releases from looking like a fresh edge against the cleared history.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of code order.
    if (reset) begin
      status_q    <= 2'b00;
      status_prev <= 2'b00;
      q_valid     <= 1'b0;
      prev_valid  <= 1'b0;
    end else begin
      status_q    <= status;
      status_prev <= status_q;
      q_valid     <= 1'b1;
      prev_valid  <= q_valid;
    end
  end

  // Events fire only on a change into FAIL or SUCCESS; 11 and held values are quiet.
  assign evt_change = prev_valid && (status_q != status_prev);
  assign fail_evt   = evt_change && (status_q == STATUS_FAIL);
  assign succ_evt   = evt_change && (status_q == STATUS_SUCCESS);
  assign take_evt   = (fail_evt || succ_evt) && (state != ST_LOCKOUT);
  assign fail_last  = (fail_cnt == FAIL_W'(MAX_FAILS - 1));

  // Timer decode: a tick completes on the last prescaler cycle of each ms.
  assign tick       = (presc == PRESC_W'(TICK_DIV - 1));
  assign hold_done  = tick && (ms == MS_W'(HOLD_MS - 1));
  assign lock_done  = tick && (ms == MS_W'(LOCK_MS - 1));
  assign blink_flip = tick && (blink == BLINK_W'(BLINK_MS - 1));

  // Count display pattern: binary (zero-extend/truncate) or saturating thermometer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    count_disp = '0;
    if (THERMO != 0) begin
      for (int i = 0; i < N_LEDS; i++) begin
        count_disp[i] = (32'(count) > 32'(i));
      end
    end else begin
      count_disp = N_LEDS'(count);
    end
  end

  // Indication FSM with registered outputs; timers run by default and are
  // cleared on every state entry and while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      fail_cnt   <= '0;
      presc      <= '0;
      ms         <= '0;
      blink      <= '0;
      tri_colour <= COLOUR_OFF;
      leds       <= '0;
    end else begin
      // NOTE: defaults here are overridden by later assignments in this block;
      // the last non-blocking assignment to a register in a cycle wins.
      leds  <= count_disp;
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        ms <= ms + 1'b1;
      end
      if (blink_flip) begin
        blink <= '0;
      end else if (tick) begin
        blink <= blink + 1'b1;
      end

      if (take_evt) begin
        presc <= '0;
        ms    <= '0;
        blink <= '0;
        if (succ_evt) begin
          fail_cnt   <= '0;
          state      <= ST_SUCCESS;
          tri_colour <= COLOUR_GREEN;
        end else if (fail_last) begin
          fail_cnt   <= '0;
          state      <= ST_LOCKOUT;
          tri_colour <= COLOUR_RED;
          leds       <= '0;
        end else begin
          fail_cnt   <= fail_cnt + 1'b1;
          state      <= ST_FAIL;
          tri_colour <= COLOUR_RED;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            presc      <= '0;
            ms         <= '0;
            blink      <= '0;
            tri_colour <= COLOUR_OFF;
          end
          ST_FAIL: begin
            if (hold_done) begin
              state      <= ST_IDLE;
              tri_colour <= COLOUR_OFF;
              presc      <= '0;
              ms         <= '0;
              blink      <= '0;
            end else if (blink_flip) begin
              tri_colour <= (tri_colour == COLOUR_RED) ? COLOUR_OFF : COLOUR_RED;
            end
          end
          ST_SUCCESS: begin
            if (hold_done) begin
              state      <= ST_IDLE;
              tri_colour <= COLOUR_OFF;
              presc      <= '0;
              ms         <= '0;
              blink      <= '0;
            end
          end
          ST_LOCKOUT: begin
            if (lock_done) begin
              state      <= ST_IDLE;
              tri_colour <= COLOUR_OFF;
              presc      <= '0;
              ms         <= '0;
              blink      <= '0;
            end else begin
              leds <= '0;
            end
          end
          default: begin
            state      <= ST_IDLE;
            tri_colour <= COLOUR_OFF;
            presc      <= '0;
            ms         <= '0;
            blink      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_status_display_gen.sv
// Bench for status_display_gen with short timing (TICK_DIV=4, HOLD_MS=5,
// BLINK_MS=2, MAX_FAILS=3, LOCK_MS=8). A binary-mode and a thermometer-mode
// instance share clock and reset. Inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns after the next one. Expected tri_colour waveforms
// are written as windows counted from the cycle an event enters its state:
// status seen at edge k is acted on at edge k+1.

module tb_status_display_gen;

  localparam int N_LEDS = 4;
  localparam int CW     = 4;

  typedef struct packed {
    logic [1:0]        tri_c;
    logic [N_LEDS-1:0] leds;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        status;
  logic [1:0]        status_th;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_th;
  logic [1:0]        tri_colour;
  logic [1:0]        tri_th;
  logic [N_LEDS-1:0] leds;
  logic [N_LEDS-1:0] leds_th;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  status_display_gen #(
    .N_LEDS(N_LEDS), .CW(CW), .TICK_DIV(4), .HOLD_MS(5), .BLINK_MS(2),
    .MAX_FAILS(3), .LOCK_MS(8), .THERMO(0)
  ) dut (
    .clk(clk), .reset(reset), .status(status), .count(count),
    .tri_colour(tri_colour), .leds(leds)
  );

  status_display_gen #(
    .N_LEDS(N_LEDS), .CW(CW), .TICK_DIV(4), .HOLD_MS(5), .BLINK_MS(2),
    .MAX_FAILS(3), .LOCK_MS(8), .THERMO(1)
  ) dut_th (
    .clk(clk), .reset(reset), .status(status_th), .count(count_th),
    .tri_colour(tri_th), .leds(leds_th)
  );

  // Drive one cycle of stimulus, queue its expectation, and hand back the
  // expectation that matches the outputs now visible.
  task automatic drive_cycle(input logic [1:0] s, input logic [CW-1:0] c,
                             input logic [CW-1:0] cth, input logic rst,
                             input logic [1:0] et, input logic [N_LEDS-1:0] el,
                             output exp_t e);
    status   = s;
    count    = c;
    count_th = cth;
    reset    = rst;
    exp_q.push_back(exp_t'{tri_c: et, leds: el});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
  endtask

  task automatic apply_reset();
    exp_t e;
    drive_cycle(2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 4'h0, e);
    drive_cycle(2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 4'h0, e);
    drive_cycle(2'b00, 4'h0, 4'h0, 1'b0, 2'b00, 4'h0, e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(2'b10, 4'hA, 4'h5, 1'b1, 2'b00, 4'h0, e);
      tests_run++;
      if (tri_colour !== e.tri_c || leds !== e.leds || tri_th !== 2'b00 || leds_th !== 4'h0) begin
        tests_failed++;
        $display("FAIL reset[%0d]: tri_colour=%b leds=%b tri_th=%b leds_th=%b, expected all zero",
                 i, tri_colour, leds, tri_th, leds_th);
      end
    end
    drive_cycle(2'b00, 4'h3, 4'h0, 1'b0, 2'b00, 4'h3, e);
    tests_run++;
    if (tri_colour !== e.tri_c || leds !== e.leds) begin
      tests_failed++;
      $display("FAIL reset_release: tri_colour=%b leds=%b, expected %b %b",
               tri_colour, leds, e.tri_c, e.leds);
    end
  endtask

  // 00 -> 10: green for exactly 20 cycles, leds follow count 0..3.
  task automatic test_success();
    exp_t        e;
    logic [3:0]  c;
    logic [1:0]  et;
    for (int i = 0; i < 23; i++) begin
      c  = 4'(i % 4);
      et = (i >= 1 && i <= 20) ? 2'b10 : 2'b00;
      drive_cycle(2'b10, c, 4'h0, 1'b0, et, c, e);
      tests_run++;
      if (tri_colour !== e.tri_c || leds !== e.leds) begin
        tests_failed++;
        $display("FAIL success[%0d]: tri_colour=%b leds=%b, expected %b %b",
                 i, tri_colour, leds, e.tri_c, e.leds);
      end
    end
  endtask

  // Single failure: red 8, off 8, red 4, then idle.
  task automatic test_fail();
    exp_t        e;
    logic [3:0]  c;
    logic [1:0]  et;
    logic [1:0]  s;
    int          r;
    for (int i = 0; i < 25; i++) begin
      c  = 4'(i % 16);
      s  = (i < 23) ? 2'b01 : 2'b00;
      r  = i - 1;
      et = (i >= 1 && (r < 8 || (r >= 16 && r < 20))) ? 2'b01 : 2'b00;
      drive_cycle(s, c, 4'h0, 1'b0, et, c, e);
      tests_run++;
      if (tri_colour !== e.tri_c || leds !== e.leds) begin
        tests_failed++;
        $display("FAIL fail_blink[%0d]: tri_colour=%b leds=%b, expected %b %b",
                 i, tri_colour, leds, e.tri_c, e.leds);
      end
    end
  endtask

  // Three failures in a row lock out for 32 cycles; a success during it is ignored.
  task automatic test_lockout();
    exp_t        e;
    logic [3:0]  c;
    logic [3:0]  el;
    logic [1:0]  et;
    logic [1:0]  s;
    apply_reset();
    for (int j = 0; j < 42; j++) begin
      c  = 4'((j + 5) % 16);
      if (j == 0 || j == 2 || j == 4) s = 2'b01;
      else if (j >= 10 && j <= 40)    s = 2'b10;
      else                            s = 2'b00;
      et = (j >= 1 && j <= 36) ? 2'b01 : 2'b00;
      el = (j >= 5 && j <= 36) ? 4'h0 : c;
      drive_cycle(s, c, 4'h0, 1'b0, et, el, e);
      tests_run++;
      if (tri_colour !== e.tri_c || leds !== e.leds) begin
        tests_failed++;
        $display("FAIL lockout[%0d]: tri_colour=%b leds=%b, expected %b %b",
                 j, tri_colour, leds, e.tri_c, e.leds);
      end
    end
  endtask

  // fail, fail, success, fail: the success clears the count, so no lockout.
  task automatic test_no_lockout();
    exp_t        e;
    logic [3:0]  c;
    logic [1:0]  et;
    logic [1:0]  s;
    int          r;
    apply_reset();
    for (int j = 0; j < 30; j++) begin
      c = 4'((j * 3) % 16);
      if (j == 0 || j == 2 || j == 6) s = 2'b01;
      else if (j == 4)                s = 2'b10;
      else                            s = 2'b00;
      r = j - 7;
      if (j == 0)                                et = 2'b00;
      else if (j <= 4)                           et = 2'b01;
      else if (j <= 6)                           et = 2'b10;
      else if (r < 8 || (r >= 16 && r < 20))     et = 2'b01;
      else                                       et = 2'b00;
      drive_cycle(s, c, 4'h0, 1'b0, et, c, e);
      tests_run++;
      if (tri_colour !== e.tri_c || leds !== e.leds) begin
        tests_failed++;
        $display("FAIL no_lockout[%0d]: tri_colour=%b leds=%b, expected %b %b",
                 j, tri_colour, leds, e.tri_c, e.leds);
      end
    end
  endtask

  // Two-cycle reset mid-success with status held at 10: abort at once, no
  // event until status goes 00 and back to 10.
  task automatic test_reset_mid_success();
    exp_t        e;
    logic [3:0]  c;
    logic [1:0]  et;
    logic [1:0]  s;
    logic        rst;
    apply_reset();
    for (int j = 0; j < 36; j++) begin
      c   = 4'(j % 16);
      s   = (j == 31) ? 2'b00 : 2'b10;
      rst = (j == 6 || j == 7);
      et  = ((j >= 1 && j <= 5) || j >= 33) ? 2'b10 : 2'b00;
      drive_cycle(s, c, 4'h0, rst, et, rst ? 4'h0 : c, e);
      tests_run++;
      if (tri_colour !== e.tri_c || leds !== e.leds) begin
        tests_failed++;
        $display("FAIL reset_mid_success[%0d]: tri_colour=%b leds=%b, expected %b %b",
                 j, tri_colour, leds, e.tri_c, e.leds);
      end
    end
  endtask

  // Thermometer instance: saturating fill from the bottom LED.
  task automatic test_thermo();
    exp_t        e;
    logic [3:0]  vals [7];
    logic [3:0]  pats [7];
    vals = '{4'd0, 4'd2, 4'd4, 4'd9, 4'd1, 4'd3, 4'd15};
    pats = '{4'b0000, 4'b0011, 4'b1111, 4'b1111, 4'b0001, 4'b0111, 4'b1111};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(2'b00, 4'h0, vals[i], 1'b0, 2'b00, pats[i], e);
      tests_run++;
      if (tri_th !== e.tri_c || leds_th !== e.leds) begin
        tests_failed++;
        $display("FAIL thermo[count=%0d]: tri_colour=%b leds=%b, expected %b %b",
                 vals[i], tri_th, leds_th, e.tri_c, e.leds);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    status    = 2'b00;
    status_th = 2'b00;
    count     = '0;
    count_th  = '0;
    test_reset();
    test_success();
    test_fail();
    test_lockout();
    test_no_lockout();
    test_reset_mid_success();
    test_thermo();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, expected to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/status_display_gen.md
STATUS_DISPLAY_GEN -- requirements
Module: status_display_gen

Interface
REQ-001 Parameter N_LEDS, default 4, SHALL set the number of count-display LEDs.
REQ-002 Parameter CW, default 4, SHALL set the width of the count input.
REQ-003 Parameter TICK_DIV, default 5000, SHALL set clk cycles per 1 ms tick (5 MHz clk).
REQ-004 Parameter HOLD_MS, default 2000, SHALL set the FAIL/SUCCESS indication duration in ticks.
REQ-005 Parameter BLINK_MS, default 250, SHALL set the FAIL blink half-period in ticks.
REQ-006 Parameter MAX_FAILS, default 3, SHALL set the consecutive failures that trigger lockout.
REQ-007 Parameter LOCK_MS, default 10000, SHALL set the lockout duration in ticks.
REQ-008 Parameter THERMO, default 0, SHALL select the count display mode: 0 = binary, 1 = thermometer.
REQ-009 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-010 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-011 status  input  2  SHALL carry 00 none, 01 failed attempt, 10 successful attempt, 11 invalid.
REQ-012 count  input  CW  SHALL carry the value to display.
REQ-013 tri_colour  output  2  SHALL drive the LED colour: 00 off, 01 red, 10 green; 11 is never driven.
REQ-014 leds  output  N_LEDS  SHALL drive the count display.

Function
REQ-015 All outputs SHALL be registered and reflect inputs/state one clk cycle after sampling.
REQ-016 status SHALL be registered each cycle; an event SHALL fire when the registered value differs from its previous registered value and the new value is 01 (FAIL event) or 10 (SUCCESS event).
REQ-017 A status of 11, or a status held constant, SHALL generate no event.
REQ-018 The state machine SHALL have the states IDLE, FAIL, SUCCESS and LOCKOUT.
REQ-019 On every state entry, the tick prescaler and ms counter SHALL clear, so a state lasting D ms exits exactly D*TICK_DIV cycles after entry.
REQ-020 In IDLE, a FAIL event SHALL increment fail_cnt; if the new value equals MAX_FAILS, the block SHALL enter LOCKOUT and clear fail_cnt, else it SHALL enter FAIL.
REQ-021 In IDLE, a SUCCESS event SHALL clear fail_cnt and enter SUCCESS.
REQ-022 In FAIL or SUCCESS, a new event SHALL be handled exactly as in IDLE, re-entering a state and restarting the timer; SUCCESS preempts FAIL.
REQ-023 FAIL and SUCCESS SHALL return to IDLE after HOLD_MS ticks with no new event.
REQ-024 LOCKOUT SHALL ignore all events and return to IDLE after LOCK_MS ticks.
REQ-025 tri_colour SHALL be 00 in IDLE, solid 10 in SUCCESS, and solid 01 in LOCKOUT.
REQ-026 In FAIL, tri_colour SHALL blink: 01 from entry, toggling with 00 every BLINK_MS ticks.
REQ-027 In binary mode, leds SHALL equal count zero-extended or truncated to N_LEDS.
REQ-028 In thermometer mode, the lowest min(count, N_LEDS) leds SHALL be 1 and the rest 0, saturating at count >= N_LEDS.
REQ-029 leds SHALL be all 0 in LOCKOUT and SHALL follow count in all other states.
REQ-030 All counters SHALL be sized with $clog2 of their maximum and SHALL never wrap within a state.

Reset
REQ-031 Reset SHALL force IDLE, fail_cnt 0, prescaler/ms counter 0, status history 00, tri_colour 00 and leds 0 on the next clk edge.
REQ-032 Reset asserted mid-FAIL, mid-SUCCESS or mid-LOCKOUT SHALL abort the indication immediately with no completion.
REQ-033 A status already nonzero when reset deasserts SHALL NOT generate an event until status changes.

Verification (TICK_DIV=4, HOLD_MS=5, BLINK_MS=2, MAX_FAILS=3, LOCK_MS=8)
REQ-034 Bench SHALL check: status 00->10 -> tri_colour 10 for exactly 20 cycles, then 00; leds track count 0..3.
REQ-035 Bench SHALL check: a single 00->01 -> tri_colour 01 for 8 cycles, 00 for 8, 01 for 4, then IDLE 00.
REQ-036 Bench SHALL check: three FAIL events without an intervening success -> third enters LOCKOUT: tri_colour 01, leds 0 for 32 cycles; a 10 event during lockout is ignored.
REQ-037 Bench SHALL check: two fails, one success, one fail -> no lockout (fail_cnt cleared by the success).
REQ-038 Bench SHALL check: reset pulse of 2 cycles mid-SUCCESS while status is held at 10 -> outputs 00/count next edge; no new event until status returns to 00 and back to 10.
REQ-039 Bench SHALL check: with THERMO=1, count values 0, 2, 4 and 9 -> leds 0000, 0011, 1111, 1111.
